// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the refill read-channel arbiter.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package mem_arb_pkg;

    localparam int ID_W = 4;

    typedef logic [1:0] arb_state_t;
    localparam arb_state_t ARB_IDLE = 2'd0;
    localparam arb_state_t ARB_ADDR = 2'd1;
    localparam arb_state_t ARB_DATA = 2'd2;

    // Index width for a requester count; never narrower than one bit.
    function automatic int grant_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin pick: first requester set after last_grant, scanning upward with wrap.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is consumed.
module rr_picker #(
    parameter int NUM_REQ = 2,
    parameter int GRANT_W = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GRANT_W-1:0] last_grant,
    output logic               vld,
    output logic [GRANT_W-1:0] winner
);

    // Walk from the farthest candidate to the nearest so the nearest set bit wins.
    always_comb begin
        vld    = 1'b0;
        winner = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            if (req[(int'(last_grant) + i) % NUM_REQ]) begin
                vld    = 1'b1;
                winner = GRANT_W'((int'(last_grant) + i) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/mem_read_arbiter.sv
// Shares one read channel among NUM_REQ refill engines, one burst outstanding at a time.
// Latency: request in IDLE at t -> m_arvalid at t+1; beats pass through combinationally.
// Backpressure: m_arready stalls the address phase; m_rready is low outside the data phase.
module mem_read_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = `ADDR_WIDTH,
    parameter int DATA_W  = `DATA_WIDTH,
    parameter int LEN_W   = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_arvalid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_araddr,
    input  logic [NUM_REQ*LEN_W-1:0]  req_arlen,
    input  logic [NUM_REQ*ID_W-1:0]   req_arid,
    output logic [NUM_REQ-1:0]      req_arready,
    output logic [NUM_REQ-1:0]      req_rvalid,
    output logic [DATA_W-1:0]       req_rdata,
    output logic                    m_arvalid,
    output logic [ADDR_W-1:0]       m_araddr,
    output logic [LEN_W-1:0]        m_arlen,
    output logic [ID_W-1:0]         m_arid,
    input  logic                    m_arready,
    input  logic                    m_rvalid,
    input  logic [DATA_W-1:0]       m_rdata,
    output logic                    m_rready,
    output logic                    busy
);

    localparam int GRANT_W = grant_w(NUM_REQ);

    arb_state_t         state;
    logic [GRANT_W-1:0] grant;
    logic [GRANT_W-1:0] last_grant;
    logic [GRANT_W-1:0] pick;
    logic               pick_vld;
    logic [ADDR_W-1:0]  addr_q;
    logic [LEN_W-1:0]   len_q;
    logic [ID_W-1:0]    id_q;
    logic [LEN_W-1:0]   beat_cnt;
    logic               in_idle;
    logic               in_addr;
    logic               in_data;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .GRANT_W (GRANT_W)
    ) u_picker (
        .req        (req_arvalid),
        .last_grant (last_grant),
        .vld        (pick_vld),
        .winner     (pick)
    );

    // Every output is held at zero while rst_n is low, independent of register contents.
    assign in_idle = rst_n && (state == ARB_IDLE);
    assign in_addr = rst_n && (state == ARB_ADDR);
    assign in_data = rst_n && (state == ARB_DATA);

    assign req_arready = (in_idle && pick_vld) ? (NUM_REQ'(1) << pick) : '0;
    assign req_rvalid  = (in_data && m_rvalid) ? (NUM_REQ'(1) << grant) : '0;
    assign req_rdata   = rst_n ? m_rdata : '0;
    assign m_arvalid   = in_addr;
    assign m_araddr    = rst_n ? addr_q : '0;
    assign m_arlen     = rst_n ? len_q : '0;
    assign m_arid      = rst_n ? id_q : '0;
    assign m_rready    = in_data;
    assign busy        = rst_n && (state != ARB_IDLE);

    // Burst sequencing: latch the winner's request, issue it, then count its beats home.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ARB_IDLE;
            grant      <= '0;
            last_grant <= GRANT_W'(NUM_REQ - 1);
            addr_q     <= '0;
            len_q      <= '0;
            id_q       <= '0;
            beat_cnt   <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (pick_vld) begin
                        grant  <= pick;
                        addr_q <= req_araddr[pick*ADDR_W +: ADDR_W];
                        len_q  <= req_arlen[pick*LEN_W +: LEN_W];
                        id_q   <= req_arid[pick*ID_W +: ID_W];
                        state  <= ARB_ADDR;
                    end
                end
                ARB_ADDR: begin
                    if (m_arready) begin
                        beat_cnt <= len_q;
                        // A zero-beat burst has nothing to return.
                        state    <= (len_q == '0) ? ARB_IDLE : ARB_DATA;
                    end
                end
                ARB_DATA: begin
                    if (m_rvalid) begin
                        beat_cnt <= beat_cnt - LEN_W'(1);
                        if (beat_cnt == LEN_W'(1)) begin
                            last_grant <= grant;
                            state      <= ARB_IDLE;
                        end
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_read_arbiter.sv
module tb_mem_read_arbiter;

    localparam int NR = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n = 1'b0;
    logic [NR-1:0]     req_arvalid = '0;
    logic [NR*AW-1:0]  req_araddr = '0;
    logic [NR*LW-1:0]  req_arlen = '0;
    logic [NR*4-1:0]   req_arid = '0;
    logic              m_arready = 1'b0;
    logic              m_rvalid = 1'b0;
    logic [DW-1:0]     m_rdata = '0;
    logic [NR-1:0]     req_arready;
    logic [NR-1:0]     req_rvalid;
    logic [DW-1:0]     req_rdata;
    logic              m_arvalid;
    logic [AW-1:0]     m_araddr;
    logic [LW-1:0]     m_arlen;
    logic [3:0]        m_arid;
    logic              m_rready;
    logic              busy;

    mem_read_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_arvalid(req_arvalid), .req_araddr(req_araddr), .req_arlen(req_arlen), .req_arid(req_arid),
        .req_arready(req_arready), .req_rvalid(req_rvalid), .req_rdata(req_rdata),
        .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arid(m_arid),
        .m_arready(m_arready), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rready(m_rready),
        .busy(busy)
    );

    // Stimulus controls (written by the test at negedge, applied by the driver after posedge)
    logic          ctl_rst = 1'b0;
    int            pend [NR];
    logic [AW-1:0] r_addr [NR];
    logic [LW-1:0] r_len [NR];
    logic [3:0]    r_id [NR];
    logic          ar_en = 1'b1;
    logic          rv_default = 1'b0;
    logic          rv_q [$];
    logic [DW-1:0] next_data = 32'hA0;
    logic [NR-1:0] acc_seen = '0;
    logic          pat [7];

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    int glog [$];
    int gcyc [$];
    logic [DW-1:0] blog [$];
    int wrong_rv = 0;

    // Reference model state: the burst in flight as a transaction record
    bit            mdl_act = 0;
    bit            mdl_adone = 0;
    int            mdl_who = 0;
    int            mdl_last = NR - 1;
    int            mdl_left = 0;
    logic [AW-1:0] mdl_addr = '0;
    logic [LW-1:0] mdl_len = '0;
    logic [3:0]    mdl_id = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int rr_pick(input logic [NR-1:0] rq, input int last);
        for (int k = 1; k <= NR; k++)
            if (rq[(last + k) % NR]) return (last + k) % NR;
        return -1;
    endfunction

    function automatic int pend_total();
        int s = 0;
        for (int i = 0; i < NR; i++) s += pend[i];
        return s;
    endfunction

    // Driver: requesters hold arvalid until accepted; memory follows ar_en and the rvalid queue
    always @(posedge clk) begin
        cyc++;
        #1;
        rst_n = ctl_rst;
        for (int i = 0; i < NR; i++) begin
            if (acc_seen[i] && pend[i] > 0) pend[i]--;
            req_arvalid[i] = ctl_rst && (pend[i] > 0);
            req_araddr[i*AW +: AW] = r_addr[i];
            req_arlen[i*LW +: LW]  = r_len[i];
            req_arid[i*4 +: 4]     = r_id[i];
        end
        m_arready = ar_en;
        if (rv_q.size() > 0) m_rvalid = rv_q.pop_front();
        else m_rvalid = rv_default;
        m_rdata = next_data;
    end

    // Monitor + model compare, every cycle at negedge
    always @(negedge clk) begin
        logic [NR-1:0] e_arready;
        logic [NR-1:0] e_rvalid;
        logic          e_arvalid;
        logic          e_rready;
        logic          e_busy;
        logic [DW-1:0] e_rdata;
        int p;
        e_arready = '0; e_rvalid = '0; e_arvalid = 1'b0; e_rready = 1'b0;
        e_busy = 1'b0; e_rdata = '0; p = -1;
        if (rst_n) begin
            e_rdata = m_rdata;
            if (!mdl_act) begin
                p = rr_pick(req_arvalid, mdl_last);
                if (p >= 0) e_arready[p] = 1'b1;
            end else begin
                e_busy = 1'b1;
                if (!mdl_adone) e_arvalid = 1'b1;
                else begin
                    e_rready = 1'b1;
                    if (m_rvalid) e_rvalid[mdl_who] = 1'b1;
                end
            end
        end
        chk("mdl_arready", req_arready, e_arready);
        chk("mdl_rvalid", req_rvalid, e_rvalid);
        chk("mdl_rdata", req_rdata, e_rdata);
        chk("mdl_arvalid", m_arvalid, e_arvalid);
        chk("mdl_rready", m_rready, e_rready);
        chk("mdl_busy", busy, e_busy);
        if (e_arvalid) begin
            chk("mdl_araddr", m_araddr, mdl_addr);
            chk("mdl_arlen", m_arlen, mdl_len);
            chk("mdl_arid", m_arid, mdl_id);
        end
        // logs for the directed checks
        acc_seen = req_arready;
        for (int i = 0; i < NR; i++)
            if (req_arready[i]) begin glog.push_back(i); gcyc.push_back(cyc); end
        if (req_rvalid != '0) begin
            blog.push_back(req_rdata);
            if (glog.size() == 0 || req_rvalid != (NR'(1) << glog[glog.size()-1])) wrong_rv++;
        end
        if (m_rvalid && m_rready) next_data++;
        // advance the model to the next cycle
        if (!rst_n) begin
            mdl_act = 0; mdl_adone = 0; mdl_last = NR - 1;
        end else if (!mdl_act) begin
            if (p >= 0) begin
                mdl_act = 1; mdl_adone = 0; mdl_who = p;
                mdl_addr = req_araddr[p*AW +: AW];
                mdl_len  = req_arlen[p*LW +: LW];
                mdl_id   = req_arid[p*4 +: 4];
            end
        end else if (!mdl_adone) begin
            if (m_arready) begin
                if (mdl_len == 0) mdl_act = 0;
                else begin mdl_adone = 1; mdl_left = int'(mdl_len); end
            end
        end else if (m_rvalid) begin
            mdl_left--;
            if (mdl_left == 0) begin mdl_act = 0; mdl_last = mdl_who; end
        end
    end

    task automatic wait_idle(input int budget);
        int k;
        bit done;
        k = 0; done = 0;
        while (!done && k < budget) begin
            @(negedge clk);
            k++;
            done = (pend_total() == 0) && !busy && (req_arvalid == '0);
        end
        n_cmp++;
        if (!done) begin
            n_bad++;
            $display("FAIL wait_idle: not idle after %0d cycles", budget);
        end
    endtask

    task automatic clear_logs();
        glog.delete(); gcyc.delete(); blog.delete(); wrong_rv = 0;
    endtask

    initial begin
        int cnt;
        bit seen;
        for (int i = 0; i < NR; i++) begin
            pend[i] = 0; r_addr[i] = '0; r_len[i] = '0; r_id[i] = '0;
        end
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_arready", req_arready, 0);
        chk("reset_arvalid", m_arvalid, 0);
        chk("reset_rready", m_rready, 0);
        ctl_rst = 1'b1;
        @(negedge clk);

        // Single request, len 4
        r_addr[0] = 32'h0000100; r_len[0] = 4'd4; r_id[0] = 4'h3;
        rv_default = 1'b1; next_data = 32'hA0; pend[0] = 1;
        @(negedge clk);
        chk("t1_arready", req_arready, 2'b01);
        chk("t1_busy_c0", busy, 0);
        @(negedge clk);
        chk("t1_arvalid", m_arvalid, 1);
        chk("t1_araddr", m_araddr, 32'h100);
        chk("t1_arlen", m_arlen, 4);
        chk("t1_arid", m_arid, 3);
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            chk("t1_rvalid", req_rvalid, 2'b01);
            chk("t1_rdata", req_rdata, 32'hA0 + b);
        end
        @(negedge clk);
        chk("t1_busy_fall", busy, 0);
        chk("t1_rready_idle", m_rready, 0);

        // Simultaneous requests right after reset
        ctl_rst = 1'b0;
        repeat (2) @(negedge clk);
        clear_logs();
        ctl_rst = 1'b1;
        r_addr[0] = 32'h200; r_len[0] = 4'd2; r_id[0] = 4'h1;
        r_addr[1] = 32'h300; r_len[1] = 4'd2; r_id[1] = 4'h2;
        pend[0] = 1; pend[1] = 1;
        wait_idle(100);
        chk("t2_grants", glog.size(), 2);
        chk("t2_first", glog[0], 0);
        chk("t2_second", glog[1], 1);
        chk("t2_gap", gcyc[1] - gcyc[0], 4);

        // Sustained contention: 6 bursts of len 2
        clear_logs();
        pend[0] = 3; pend[1] = 3;
        wait_idle(200);
        chk("t3_grants", glog.size(), 6);
        for (int k = 0; k < 6; k++) chk("t3_order", glog[k], k % 2);
        chk("t3_beats", blog.size(), 12);
        chk("t3_wrong_rvalid", wrong_rv, 0);

        // ARREADY stall for 5 cycles
        clear_logs();
        ar_en = 1'b0;
        r_addr[0] = 32'h400; r_len[0] = 4'd1; r_id[0] = 4'h5;
        r_addr[1] = 32'h500; r_len[1] = 4'd1; r_id[1] = 4'h6;
        pend[0] = 1; pend[1] = 1;
        @(negedge clk);
        chk("t4_arready", req_arready, 2'b01);
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            chk("t4_arvalid", m_arvalid, 1);
            chk("t4_araddr", m_araddr, 32'h400);
            chk("t4_arlen", m_arlen, 1);
            chk("t4_arid", m_arid, 5);
            chk("t4_no_arready", req_arready, 0);
            if (s == 4) ar_en = 1'b1;
        end
        wait_idle(100);
        chk("t4_grants", glog.size(), 2);
        chk("t4_second", glog[1], 1);

        // Gapped beats with len 4
        clear_logs();
        rv_default = 1'b0;
        r_addr[0] = 32'h600; r_len[0] = 4'd4; r_id[0] = 4'h9;
        pend[0] = 1;
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            seen = m_arvalid && m_arready;
        end
        chk("t5_addr_done", seen, 1);
        for (int k = 0; k < 7; k++) rv_q.push_back(pat[k]);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            chk("t5_rvalid", req_rvalid, pat[k] ? 2'b01 : 2'b00);
            if (k == 6) rv_default = 1'b1;
        end
        @(negedge clk);
        chk("t5_busy", busy, 0);
        chk("t5_stray_rready", m_rready, 0);
        chk("t5_beats", blog.size(), 4);

        // Reset mid-DATA after 2 of 8 beats
        clear_logs();
        r_addr[0] = 32'h700; r_len[0] = 4'd8; r_id[0] = 4'hA;
        pend[0] = 1;
        cnt = 0;
        for (int k = 0; k < 30 && cnt < 2; k++) begin
            @(negedge clk);
            if (req_rvalid[0]) cnt++;
        end
        chk("t6_two_beats", cnt, 2);
        ctl_rst = 1'b0; pend[0] = 0; pend[1] = 0;
        @(negedge clk);
        chk("t6_busy", busy, 0);
        chk("t6_arvalid", m_arvalid, 0);
        chk("t6_rready", m_rready, 0);
        chk("t6_rvalid", req_rvalid, 0);
        chk("t6_rdata", req_rdata, 0);
        @(negedge clk);
        chk("t6_busy2", busy, 0);
        ctl_rst = 1'b1;
        r_addr[1] = 32'h800; r_len[1] = 4'd1; r_id[1] = 4'h7;
        pend[1] = 1;
        @(negedge clk);
        chk("t6_req1_arready", req_arready, 2'b10);
        @(negedge clk);
        chk("t6_req1_arvalid", m_arvalid, 1);
        chk("t6_req1_araddr", m_araddr, 32'h800);
        wait_idle(50);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
